// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative float32 divider, radix-2 restoring, one quotient bit per cycle.
// Truncating (round-toward-zero); subnormal operands are flushed to zero.
module fp_div_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero,
    output logic        invalid
);
    typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [25:0] r_q, r_d;
    logic [24:0] qt_q, qt_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d, inv_q, inv_d;

    logic        ge;
    logic [25:0] fb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign;
    logic signed [9:0] e;

    // Any zero, inf or NaN operand bypasses the divide loop.
    function automatic logic special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'd0) || (a[30:23] == 8'hFF) || (b[30:23] == 8'd0) || (b[30:23] == 8'hFF);
    endfunction

    always_comb begin
        fb     = {3'b001, b_q[22:0]};
        ge     = r_q >= fb;
        sign   = a_q[31] ^ b_q[31];
        a_zero = a_q[30:23] == 8'd0;
        b_zero = b_q[30:23] == 8'd0;
        a_inf  = a_q[30:23] == 8'hFF && a_q[22:0] == 23'd0;
        b_inf  = b_q[30:23] == 8'hFF && b_q[22:0] == 23'd0;
        a_nan  = a_q[30:23] == 8'hFF && a_q[22:0] != 23'd0;
        b_nan  = b_q[30:23] == 8'hFF && b_q[22:0] != 23'd0;
        e      = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]})
                 + (qt_q[24] ? 10'sd127 : 10'sd126);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        qt_d     = qt_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        dbz_d    = dbz_q;
        inv_d    = inv_q;
        case (state_q)
            IDLE: if (start) begin
                a_d     = A;
                b_d     = B;
                busy_d  = 1'b1;
                r_d     = {3'b001, A[22:0]};
                qt_d    = '0;
                cnt_d   = '0;
                state_d = special(A, B) ? NORM : DIV;
            end
            DIV: begin
                r_d     = (ge ? r_q - fb : r_q) << 1;
                qt_d    = {qt_q[23:0], ge};
                cnt_d   = cnt_q + 5'd1;
                state_d = (cnt_q == 5'd24) ? NORM : DIV;
            end
            NORM: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                dbz_d   = 1'b0;
                inv_d   = 1'b0;
                if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                    result_d = 32'h7FC00000;
                    inv_d    = 1'b1;
                end else if (b_zero) begin
                    result_d = {sign, 8'hFF, 23'd0};
                    dbz_d    = 1'b1;
                end else if (a_inf) begin
                    result_d = {sign, 8'hFF, 23'd0};
                end else if (a_zero || b_inf) begin
                    result_d = {sign, 31'd0};
                end else if (e >= 10'sd255) begin
                    result_d = {sign, 8'hFF, 23'd0};
                    ovf_d    = 1'b1;
                end else if (e <= 10'sd0) begin
                    result_d = {sign, 31'd0};
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign, e[7:0], qt_q[24] ? qt_q[23:1] : qt_q[22:0]};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            qt_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            qt_q     <= qt_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dbz_q    <= dbz_d;
            inv_q    <= inv_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign div_by_zero = dbz_q;
    assign invalid     = inv_q;
endmodule
